// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the instruction-fetch FSM state type.
package axi_pkg;

    localparam int          ID_WIDTH    = 4;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Substituted for the fetched word whenever the beat is bad.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_axi_master.sv
// IF-stage fetch master: one single-beat AXI4 read per fetch_req, with flush
// support and a stall output that holds the PC register while busy.
module if_fetch_axi_master
    import axi_pkg::*;
#(
    parameter int                     pc_size   = 32,
    parameter int                     data_size = 32,
    parameter int                     id_width  = ID_WIDTH,
    parameter logic [id_width-1:0]    master_id = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [pc_size-1:0]    fetch_pc,
    input  logic                  flush,
    output logic [data_size-1:0]  instr,
    output logic                  instr_valid,
    output logic                  fetch_err,
    output logic                  stall,
    output logic [id_width-1:0]   ARID,
    output logic [pc_size-1:0]    ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [id_width-1:0]   RID,
    input  logic [data_size-1:0]  RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output fetch_state_e          dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk edge where VALID and
    // READY are both high; ARVALID is held with a stable ARADDR until then.

    fetch_state_e          state_q;
    logic [pc_size-1:0]    araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  flush_seen_q;
    logic [data_size-1:0]  instr_q;
    logic                  instr_valid_q;
    logic                  fetch_err_q;
    logic                  beat_err;
    logic                  unused_pc_lo;

    assign unused_pc_lo = ^fetch_pc[1:0];

    // A wrong RID is treated exactly like a slave error.
    assign beat_err = (RRESP != RESP_OKAY) || (RID != master_id);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            flush_seen_q  <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_req) begin
                        araddr_q     <= {fetch_pc[pc_size-1:2], 2'b00};
                        arvalid_q    <= 1'b1;
                        flush_seen_q <= 1'b0;
                        state_q      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // A flush cannot retract the address; remember it and
                    // swallow the data beat later instead.
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (flush || flush_seen_q) ? ST_DROP : ST_DATA;
                    end else if (flush) begin
                        flush_seen_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (RVALID && RLAST) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (!flush) begin
                            instr_valid_q <= 1'b1;
                            fetch_err_q   <= beat_err;
                            instr_q       <= beat_err ? data_size'(NOP_INSTR) : RDATA;
                        end
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (RVALID && RLAST) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall       = (state_q != ST_IDLE) || fetch_req;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign ARID        = master_id;
    assign ARADDR      = araddr_q;
    assign ARLEN       = 4'd0;
    assign ARSIZE      = SIZE_WORD;
    assign ARBURST     = BURST_INCR;
    assign ARVALID     = arvalid_q;
    assign RREADY      = rready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch_axi_master.sv
// Directed bench for if_fetch_axi_master with a small AXI read slave and an
// instruction scoreboard.
module tb_if_fetch_axi_master;
    import axi_pkg::*;

    logic         clk;
    logic         rst;
    logic         fetch_req;
    logic [31:0]  fetch_pc;
    logic         flush;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         fetch_err;
    logic         stall;
    logic [3:0]   ARID;
    logic [31:0]  ARADDR;
    logic [3:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY;
    logic [3:0]   RID;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;
    fetch_state_e dbg_state;

    typedef struct packed {
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] data;
    } r_beat_t;

    r_beat_t     r_q[$];
    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ar_wait = 0;
    int          ar_hs_count = 0;

    if_fetch_axi_master dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .flush(flush), .instr(instr), .instr_valid(instr_valid),
        .fetch_err(fetch_err), .stall(stall), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .dbg_state_o(dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI read slave: ARREADY after ar_wait stalled cycles, R beat one cycle
    // after the AR handshake, data taken from r_q.
    initial begin
        logic ar_hs, r_hs, rst_s, r_pend;
        int   ar_cnt;
        r_beat_t b;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0;
        r_pend = 1'b0; ar_cnt = 0;
        forever begin
            @(negedge clk);
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            rst_s = rst;
            @(posedge clk);
            #1;
            if (rst_s) begin
                ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
                r_pend = 1'b0; ar_cnt = 0;
            end else begin
                if (r_hs) begin
                    RVALID = 1'b0; RLAST = 1'b0;
                end
                if (ar_hs) begin
                    r_pend = 1'b1; ar_cnt = 0; ar_hs_count++;
                end
                if (r_pend && !RVALID) begin
                    b = (r_q.size() != 0) ? r_q.pop_front() : '0;
                    RRESP = b.resp; RID = b.id; RDATA = b.data;
                    RVALID = 1'b1; RLAST = 1'b1; r_pend = 1'b0;
                end
                ARREADY = ARVALID && (ar_cnt >= ar_wait);
                if (ARVALID && !ARREADY) ar_cnt++;
            end
        end
    end

    // Scoreboard monitor: every instr_valid pulse pops one expected {err, instr}.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && instr_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_instr: got instr=0x%0h err=%0b expected no pulse", instr, fetch_err);
            end else begin
                e = exp_q.pop_front();
                if ({fetch_err, instr} !== e) begin
                    n_err++;
                    $display("FAIL instr_word: got err=%0b instr=0x%0h expected err=%0b instr=0x%0h",
                             fetch_err, instr, e[32], e[31:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(dbg_state == ST_IDLE && !instr_valid && exp_q.size() == 0) && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(name, 64'(k < 50), 64'd1);
    endtask

    task automatic push(input logic [1:0] resp, input logic [3:0] id, input logic [31:0] data,
                        input logic exp_err, input logic [31:0] exp_instr, input logic expect_out);
        r_q.push_back('{resp: resp, id: id, data: data});
        if (expect_out) exp_q.push_back({exp_err, exp_instr});
    endtask

    task automatic single_fetch(input logic [31:0] pc);
        fetch_req = 1'b1; fetch_pc = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin
        int hs0;
        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // Zero-wait fetch
        ar_wait = 0;
        push(RESP_OKAY, 4'd0, 32'h00A0_0093, 1'b0, 32'h00A0_0093, 1'b1);
        fetch_req = 1'b1; fetch_pc = 32'h0000_0104;
        @(negedge clk);
        check("zw_stall_n0", stall, 1);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("zw_arvalid_n1", ARVALID, 1);
        check("zw_araddr_n1", ARADDR, 32'h104);
        check("zw_stall_n1", stall, 1);
        check("zw_ar_const", {ARID, ARLEN, ARSIZE, ARBURST}, {4'd0, 4'd0, 3'b010, 2'b01});
        tick();
        @(negedge clk);
        check("zw_rready_n2", RREADY, 1);
        check("zw_stall_n2", stall, 1);
        check("zw_valid_n2", instr_valid, 0);
        tick();
        @(negedge clk);
        check("zw_valid_n3", instr_valid, 1);
        check("zw_stall_n3", stall, 0);
        tick();

        // Unaligned PC with AR backpressure
        ar_wait = 3;
        hs0 = ar_hs_count;
        push(RESP_OKAY, 4'd0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1);
        single_fetch(32'h0000_0106);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_arvalid", ARVALID, 1);
            check("bp_araddr", ARADDR, 32'h104);
            tick();
        end
        wait_idle("bp_done");
        check("bp_ar_count", ar_hs_count - hs0, 1);
        tick();

        // Flush while the address is still waiting
        ar_wait = 2;
        hs0 = ar_hs_count;
        push(RESP_OKAY, 4'd0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        single_fetch(32'h0000_0200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_arvalid_held", ARVALID, 1);
        tick();
        tick();
        @(negedge clk);
        check("fl_state_drop", dbg_state, ST_DROP);
        check("fl_rready_drop", RREADY, 1);
        tick();
        @(negedge clk);
        check("fl_state_idle", dbg_state, ST_IDLE);
        check("fl_no_valid", instr_valid, 0);
        check("fl_ar_count", ar_hs_count - hs0, 1);
        tick();

        // Error responses: SLVERR and a wrong RID both give NOP + fetch_err
        ar_wait = 0;
        push(RESP_SLVERR, 4'd0, 32'h1111_1111, 1'b1, 32'h0000_0013, 1'b1);
        single_fetch(32'h0000_0300);
        wait_idle("err_resp_done");
        push(RESP_OKAY, 4'd5, 32'h2222_2222, 1'b1, 32'h0000_0013, 1'b1);
        single_fetch(32'h0000_0304);
        wait_idle("err_rid_done");
        tick();

        // Flush in the same cycle as the R handshake drops the word
        push(RESP_OKAY, 4'd0, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
        single_fetch(32'h0000_0400);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fd_state_idle", dbg_state, ST_IDLE);
        check("fd_no_valid", instr_valid, 0);
        tick();

        // Back-to-back fetches with fetch_req held high
        hs0 = ar_hs_count;
        push(RESP_OKAY, 4'd0, 32'h0010_0113, 1'b0, 32'h0010_0113, 1'b1);
        push(RESP_OKAY, 4'd0, 32'h0020_0193, 1'b0, 32'h0020_0193, 1'b1);
        fetch_req = 1'b1; fetch_pc = 32'h0000_0100;
        tick();
        fetch_pc = 32'h0000_0104;
        @(negedge clk);
        check("b2b_araddr0", ARADDR, 32'h100);
        tick();
        tick();
        @(negedge clk);
        check("b2b_valid0", instr_valid, 1);
        check("b2b_arvalid_gap", ARVALID, 0);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("b2b_arvalid1", ARVALID, 1);
        check("b2b_araddr1", ARADDR, 32'h104);
        wait_idle("b2b_done");
        check("b2b_ar_count", ar_hs_count - hs0, 2);
        tick();

        // Reset while in DATA
        push(RESP_OKAY, 4'd0, 32'h4444_4444, 1'b0, 32'h0, 1'b0);
        single_fetch(32'h0000_0500);
        tick();
        @(negedge clk);
        check("mr_state_data", dbg_state, ST_DATA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_arvalid", ARVALID, 0);
        check("mr_rready", RREADY, 0);
        check("mr_valid", instr_valid, 0);
        check("mr_state", dbg_state, ST_IDLE);
        check("mr_instr", instr, 0);
        repeat (3) tick();

        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_r_q_empty", r_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
